// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkg : shared defaults, read-mode constants and helpers for the FIFO family
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package fifo_pkg;

   localparam int C_D_W  = 8;
   localparam int C_AD_W = 4;

   // Read-mode selectors, also used by the existing fifo bench
   localparam int MODE_STD  = 0;
   localparam int MODE_FWFT = 1;

   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
//------------------------------------------------------------------------------
// fifo_mem : 2**ad_w x d_w register array, synchronous write, asynchronous read
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int d_w  = C_D_W,
   parameter int ad_w = C_AD_W
)(
   input  logic            clk,
   input  logic            wr_en,
   input  logic [ad_w-1:0] wr_addr,
   input  logic [d_w-1:0]  wr_data,
   input  logic [ad_w-1:0] rd_addr,
   output logic [d_w-1:0]  rd_data
);

   localparam int c_depth = 2**ad_w;

   // Storage is deliberately left unreset
   logic [d_w-1:0] r_mem [c_depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule : fifo_mem

`default_nettype wire

// File: rtl/fifo_flags.sv
//------------------------------------------------------------------------------
// fifo_flags : single-clock FIFO with programmable thresholds, occupancy count,
//              sticky error flags and a compile-time FWFT read mode
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fifo_flags
   import fifo_pkg::*;
#(
   parameter int d_w    = C_D_W,
   parameter int ad_w   = C_AD_W,
   parameter int af_lvl = 14,
   parameter int ae_lvl = 2,
   parameter int fwft   = MODE_STD
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           write,
   input  logic           read,
   input  logic [d_w-1:0] data_in,
   output logic [d_w-1:0] data_out,
   output logic           full,
   output logic           empty,
   output logic           almost_full,
   output logic           almost_empty,
   output logic [ad_w:0]  count,
   output logic           overflow,
   output logic           underflow,
   input  logic           err_clr
);

   localparam int            c_depth_i  = 2**ad_w;
   localparam logic [ad_w:0] c_depth    = {1'b1, {ad_w{1'b0}}};
   localparam logic [ad_w:0] c_one      = {{ad_w{1'b0}}, 1'b1};
   localparam logic [ad_w:0] c_af_lvl   = af_lvl[ad_w:0];
   localparam logic [ad_w:0] c_ae_lvl   = ae_lvl[ad_w:0];
   localparam logic [ad_w-1:0] c_ptr_one = {{(ad_w-1){1'b0}}, 1'b1};

   // Elaboration-time parameter legality
   if (af_lvl < 1 || af_lvl > c_depth_i) begin : g_bad_af_lvl
      $error("fifo_flags: af_lvl=%0d outside legal range 1..%0d", af_lvl, c_depth_i);
   end
   if (ae_lvl < 0 || ae_lvl >= c_depth_i) begin : g_bad_ae_lvl
      $error("fifo_flags: ae_lvl=%0d outside legal range 0..%0d", ae_lvl, c_depth_i - 1);
   end
   if (fwft != MODE_STD && fwft != MODE_FWFT) begin : g_bad_mode
      $error("fifo_flags: fwft=%0d must be %0d or %0d", fwft, MODE_STD, MODE_FWFT);
   end
   if (ad_w < 1 || clog2(c_depth_i) != ad_w) begin : g_bad_ad_w
      $error("fifo_flags: ad_w=%0d is not a usable address width", ad_w);
   end

   logic [ad_w-1:0] r_wr_ptr;
   logic [ad_w-1:0] r_rd_ptr;
   logic [ad_w:0]   r_count;
   logic            r_overflow;
   logic            r_underflow;

   logic            w_full;
   logic            w_empty;
   logic            w_rd_acc;
   logic            w_wr_acc;
   logic            w_ovf_evt;
   logic            w_unf_evt;
   logic [d_w-1:0]  w_mem_rd;

   assign w_full   = (r_count == c_depth);
   assign w_empty  = (r_count == '0);

   // A read frees a slot in the same edge, so a full FIFO still takes a paired write
   assign w_rd_acc  = read && !w_empty;
   assign w_wr_acc  = write && (!w_full || w_rd_acc);
   assign w_ovf_evt = write && !w_wr_acc;
   assign w_unf_evt = read && !w_rd_acc;

   fifo_mem #(
      .d_w  (d_w),
      .ad_w (ad_w)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_wr_acc),
      .wr_addr (r_wr_ptr),
      .wr_data (data_in),
      .rd_addr (r_rd_ptr),
      .rd_data (w_mem_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + c_one;
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - c_one;
         end
      end
   end

   // A fresh error in the clearing cycle takes priority over err_clr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_evt) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_unf_evt) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   if (fwft == MODE_FWFT) begin : g_fwft
      assign data_out = w_empty ? '0 : w_mem_rd;
   end else begin : g_std
      logic [d_w-1:0] r_data_out;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_data_out <= '0;
         end else if (w_rd_acc) begin
            r_data_out <= w_mem_rd;
         end
      end

      assign data_out = r_data_out;
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_af_lvl);
   assign almost_empty = (r_count <= c_ae_lvl);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule : fifo_flags

`default_nettype wire

// File: tb/tb_fifo_flags.sv
//------------------------------------------------------------------------------
// tb_fifo_flags : directed bench for fifo_flags, standard and FWFT builds side by side
// Revision      : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_flags;
   import fifo_pkg::*;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       write   = 1'b0;
   logic       read    = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic [7:0] s_dout, f_dout;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0] s_count, f_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_flags #(
      .d_w(8), .ad_w(4), .af_lvl(14), .ae_lvl(2), .fwft(MODE_STD)
   ) u_std (
      .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
      .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf),
      .err_clr(err_clr)
   );

   fifo_flags #(
      .d_w(8), .ad_w(4), .af_lvl(14), .ae_lvl(2), .fwft(MODE_FWFT)
   ) u_fwft (
      .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
      .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf),
      .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Occupancy-derived flags of the standard build against depth 16, af 14, ae 2
   task automatic flags(input string tag, input int n);
      check({tag, ".count"}, 32'(s_count), n);
      check({tag, ".empty"}, 32'(s_empty), 32'(n == 0));
      check({tag, ".full"},  32'(s_full),  32'(n == 16));
      check({tag, ".af"},    32'(s_af),    32'(n >= 14));
      check({tag, ".ae"},    32'(s_ae),    32'(n <= 2));
   endtask

   task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic clr);
      write   = w;
      read    = r;
      data_in = d;
      err_clr = clr;
      @(posedge clk);
      #1;
      write   = 1'b0;
      read    = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      // 1: reset then idle
      #18 rst = 1'b1;
      #1;
      flags("rst", 0);
      check("rst.s_dout", 32'(s_dout), 0);
      check("rst.f_dout", 32'(f_dout), 0);
      check("rst.ovf", 32'(s_ovf), 0);
      check("rst.unf", 32'(s_unf), 0);
      check("rst.f_empty", 32'(f_empty), 1);

      // 2: fill, overflow, drain
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, 8'(i), 1'b0);
         flags("fill", i + 1);
      end
      cyc(1'b1, 1'b0, 8'hAA, 1'b0);
      check("ovf.set", 32'(s_ovf), 1);
      check("ovf.f_set", 32'(f_ovf), 1);
      flags("ovf", 16);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0);
         check("drain.s_dout", 32'(s_dout), i);
         check("drain.f_dout", 32'(f_dout), (i == 15) ? 0 : i + 1);
         flags("drain", 15 - i);
      end
      check("drain.unf", 32'(s_unf), 0);

      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check("clr.ovf", 32'(s_ovf), 0);
      check("clr.f_ovf", 32'(f_ovf), 0);

      // 3: simultaneous read/write at full, then at empty
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
      flags("refill", 16);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, 8'(8'h80 + k), 1'b0);
         check("rw_full.s_dout", 32'(s_dout), k);
         check("rw_full.f_dout", 32'(f_dout), k + 1);
         check("rw_full.count", 32'(s_count), 16);
         check("rw_full.ovf", 32'(s_ovf), 0);
      end
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0);
         check("rw_drain", 32'(s_dout), (i < 12) ? i + 4 : 8'h80 + i - 12);
      end
      flags("rw_drained", 0);
      cyc(1'b1, 1'b1, 8'h77, 1'b0);
      flags("rw_empty", 1);
      check("rw_empty.unf", 32'(s_unf), 1);
      check("rw_empty.s_hold", 32'(s_dout), 8'h83);
      check("rw_empty.f_dout", 32'(f_dout), 8'h77);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("rw_empty.pop", 32'(s_dout), 8'h77);
      flags("rw_pop", 0);
      cyc(1'b0, 1'b1, 8'h00, 1'b1);
      check("clr_vs_err.unf", 32'(s_unf), 1);
      check("clr_vs_err.hold", 32'(s_dout), 8'h77);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check("clr.unf", 32'(s_unf), 0);

      // 4: wrap-around
      for (int rep = 0; rep < 3; rep++) begin
         for (int j = 0; j < 10; j++) cyc(1'b1, 1'b0, 8'(rep * 16 + j), 1'b0);
         flags("wrap_fill", 10);
         for (int j = 0; j < 10; j++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            check("wrap.s_dout", 32'(s_dout), rep * 16 + j);
         end
         flags("wrap_empty", 0);
         check("wrap.ovf", 32'(s_ovf), 0);
         check("wrap.unf", 32'(s_unf), 0);
      end

      // 5: asynchronous reset with data stored
      for (int j = 0; j < 7; j++) cyc(1'b1, 1'b0, 8'(8'hC0 + j), 1'b0);
      flags("pre_rst", 7);
      #2 rst = 1'b0;
      #1;
      flags("async_rst", 0);
      check("async_rst.s_dout", 32'(s_dout), 0);
      check("async_rst.f_dout", 32'(f_dout), 0);
      check("async_rst.f_count", 32'(f_count), 0);
      #3 rst = 1'b1;
      cyc(1'b1, 1'b0, 8'h55, 1'b0);
      check("post_rst.f_dout", 32'(f_dout), 8'h55);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("post_rst.s_dout", 32'(s_dout), 8'h55);
      flags("post_rst", 0);

      // 6: FWFT presentation and pop
      check("fwft.idle", 32'(f_dout), 0);
      cyc(1'b1, 1'b0, 8'h3C, 1'b0);
      check("fwft.show", 32'(f_dout), 8'h3C);
      check("fwft.not_empty", 32'(f_empty), 0);
      check("fwft.std_hold", 32'(s_dout), 8'h55);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("fwft.empty", 32'(f_empty), 1);
      check("fwft.zero", 32'(f_dout), 0);
      check("fwft.count", 32'(f_count), 0);
      check("fwft.std_pop", 32'(s_dout), 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fifo_flags

`default_nettype wire

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Synchronous single-clock FIFO. Next generation of the team's basic `fifo`; drop-in for that block at the same `clk` rate.
- Adds the following:
  - programmable almost-full and almost-empty thresholds
  - an occupancy count output
  - sticky overflow and underflow error flags with a clear input
  - a compile-time first-word-fall-through (FWFT) mode
- Sits between producer and consumer datapaths that need early back-pressure and error visibility.

Parameters:
- d_w, 8, data word width in bits.
- ad_w, 4, address width; depth = 2**ad_w (16 by default).
- af_lvl, 14, almost_full asserts when count >= af_lvl. Legal range 1..depth.
- ae_lvl, 2, almost_empty asserts when count <= ae_lvl. Legal range 0..depth-1.
- fwft, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- write  in  1  push request.
- read  in  1  pop request.
- data_in  in  d_w  write data.
- data_out  out  d_w  read data.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_lvl.
- almost_empty  out  1  count <= ae_lvl.
- count  out  ad_w+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was ignored.
- err_clr  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - read pointer, write pointer, count = 0.
  - data_out = 0; empty = 1; almost_empty = 1; full = 0; almost_full = 0; overflow = 0; underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data immediately. The first accepted write after release lands at address 0.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered count.
  - All flags update in the cycle after the edge that changed count.
- Write accept: write && (!full || read_accept).
  - Accepted data goes to mem[wr_ptr]; wr_ptr increments modulo depth (wraps naturally in ad_w bits).
- Read accept: read && !empty. rd_ptr increments modulo depth.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full plus simultaneous read and write: both accepted, count stays at depth, no overflow.
- Empty plus simultaneous read and write: write accepted, read ignored, underflow set, count becomes 1.
- Errors:
  - write while full with no read accept: data dropped, pointers unchanged, overflow <= 1.
  - read while empty: underflow <= 1, data_out holds.
  - Both flags hold until err_clr=1 at a clock edge.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag = 1).
- fwft=0 (standard mode):
  - On read accept, data_out <= mem[rd_ptr] at that edge: one-cycle latency.
  - Otherwise data_out holds its previous value.
- fwft=1:
  - data_out = mem[rd_ptr] combinationally whenever !empty; it is 0 when empty.
  - The first word becomes visible the cycle after its write edge.
  - read acknowledges and pops the currently shown word.
- Pointers are ad_w bits. Full/empty are derived from count, not from pointer compare.
- Illegal parameter combinations (af_lvl > depth, ae_lvl >= depth) must be rejected at elaboration with an error message.

Decomposition:
- Shared package/header fifo_pkg holds:
  - default d_w and ad_w constants
  - a clog2 function
  - the FWFT/standard mode constants (MODE_STD = 0, MODE_FWFT = 1), shared with the existing fifo bench.
- One sub-module, fifo_mem:
  - dual-port register array, depth 2**ad_w by d_w
  - one synchronous write port and one asynchronous read port.
- fifo_flags adds a registered output stage in standard mode only.

Test Plan:
1. Reset then idle: rst=0 for 18 ns, release → empty=1, almost_empty=1, count=0, data_out=0; all other flags 0.
2. Fill: 16 writes of 0x00..0x0F → almost_full rises after the 14th write (count=14), full after the 16th. A 17th write (0xAA) sets overflow; count stays 16. Then 16 reads (fwft=0) → 0x00..0x0F each one cycle after its read; empty=1 at the end.
3. Simultaneous: at full, read=write=1 for 4 cycles → count stays 16, overflow stays 0, and outputs are 0x00..0x03 in order. At empty, read=write=1 → count becomes 1 and underflow=1.
4. Wrap-around: 10 writes, 10 reads, repeated 3 times (30 words, pointers wrap) → data order preserved, count returns to 0 each time, no error flags.
5. Error clear and reset mid-run: pulse err_clr → overflow=0 and underflow=0 next edge. Assert rst with count=7 → all outputs return to reset values immediately. Next write of 0x55 then a read returns 0x55.
6. fwft=1 build: write 0x3C → data_out=0x3C one cycle later with no read. read=1 pops it; empty=1 and data_out=0 on the following cycle.
